i3c_engine_arbiter: RTL and testbench

- Schedules the controller's protocol engines onto the shared datapath: register-file ports, SCL push-pull/open-drain control, TX/RX, and frame/bit counters.
- Engines: SDR, IBI, Hot-Join, DAA and Secondary-Controller.
- Accepts one request per engine and picks a winner by fixed priority with an SDR anti-starvation guard.
- Drives the shared mux-select code, issues a one-hot grant, waits for the engine's done, and aborts hung engines with a watchdog.
- Sits between the engine blocks and the datapath muxes, replacing ad-hoc mux-select driving in the top-level control FSM.

---
 rtl/i3c_arb_pkg.sv | 31 +++
 rtl/i3c_engine_arbiter_if.sv | 35 +++
 rtl/i3c_arb_watchdog.sv | 36 +++
 rtl/i3c_engine_arbiter.sv | 111 +++++++++++
 tb/tb_i3c_engine_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/i3c_arb_pkg.sv
// Shared definitions for the engine arbiter: datapath select codes, request bit indices
// and the Gray-coded FSM state encoding.
package i3c_arb_pkg;

  localparam int unsigned NumEng = 5;

  // Select codes are shared with the datapath muxes.
  localparam logic [2:0] SDR_SEL = 3'd0;
  localparam logic [2:0] IBI_SEL = 3'd1;
  localparam logic [2:0] HJ_SEL  = 3'd2;
  localparam logic [2:0] DAA_SEL = 3'd3;
  localparam logic [2:0] SC_SEL  = 3'd4;

  localparam int unsigned SDR_IDX = 0;
  localparam int unsigned IBI_IDX = 1;
  localparam int unsigned HJ_IDX  = 2;
  localparam int unsigned DAA_IDX = 3;
  localparam int unsigned SC_IDX  = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StSetup   = 2'b01,
    StActive  = 2'b11,
    StRelease = 2'b10
  } arb_state_e;

  function automatic logic [NumEng-1:0] sel_to_onehot(logic [2:0] sel);
    return NumEng'(1) << sel;
  endfunction

endpackage

// File: rtl/i3c_engine_arbiter_if.sv
// Engine-side handshake bundle of the arbiter: requests, dones, grant and datapath select.
interface i3c_engine_arbiter_if;

  logic       i_arb_en;
  logic [4:0] i_arb_req;
  logic [4:0] i_arb_done;
  logic [4:0] o_arb_gnt;
  logic [2:0] o_arb_mux_sel;
  logic       o_arb_busy;
  logic       o_arb_abort;
  logic       o_arb_timeout;

  modport master (
    input  i_arb_en,
    input  i_arb_req,
    input  i_arb_done,
    output o_arb_gnt,
    output o_arb_mux_sel,
    output o_arb_busy,
    output o_arb_abort,
    output o_arb_timeout
  );

  modport slave (
    output i_arb_en,
    output i_arb_req,
    output i_arb_done,
    input  o_arb_gnt,
    input  o_arb_mux_sel,
    input  o_arb_busy,
    input  o_arb_abort,
    input  o_arb_timeout
  );

endinterface

// File: rtl/i3c_arb_watchdog.sv
// Clear/enable cycle counter; expire_o flags the last permitted cycle (TO_CYCLES-1).
module i3c_arb_watchdog #(
  parameter int unsigned TO_CYCLES = 20000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TO_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TO_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i3c_engine_arbiter.sv
// Fixed-priority arbiter scheduling the protocol engines onto the shared datapath, with an
// SDR anti-starvation age counter and a per-grant watchdog.
module i3c_engine_arbiter
  import i3c_arb_pkg::*;
#(
  parameter int unsigned TO_CYCLES = 20000,
  parameter int unsigned AGE_MAX   = 4
) (
  input logic                  i_arb_clk,
  input logic                  i_arb_rst_n,
  i3c_engine_arbiter_if.master bus
);

  localparam int unsigned AgeW = $clog2(AGE_MAX + 1);
  localparam logic [AgeW-1:0] AgeSat = AgeW'(AGE_MAX);

  arb_state_e        state_q;
  logic [2:0]        sel_q;
  logic [NumEng-1:0] gnt_q;
  logic [AgeW-1:0]   age_q;
  logic              sdr_pend_q;

  logic [2:0] winner;
  logic       req_sel, done_sel;
  logic       wd_expire;
  logic       abort;

  always_comb begin
    winner = SDR_SEL;
    if (bus.i_arb_req[SDR_IDX] && (age_q == AgeSat)) begin
      winner = SDR_SEL;
    end else if (bus.i_arb_req[IBI_IDX]) begin
      winner = IBI_SEL;
    end else if (bus.i_arb_req[HJ_IDX]) begin
      winner = HJ_SEL;
    end else if (bus.i_arb_req[DAA_IDX]) begin
      winner = DAA_SEL;
    end else if (bus.i_arb_req[SC_IDX]) begin
      winner = SC_SEL;
    end
  end

  assign req_sel  = bus.i_arb_req[sel_q];
  assign done_sel = bus.i_arb_done[sel_q];
  // Must see done in the expiry cycle itself, so abort cannot be registered ahead of time.
  assign abort    = (state_q == StActive) && wd_expire && !done_sel;

  i3c_arb_watchdog #(
    .TO_CYCLES(TO_CYCLES)
  ) u_watchdog (
    .clk_i   (i_arb_clk),
    .rst_ni  (i_arb_rst_n),
    .clr_i   (state_q == StSetup),
    .en_i    (state_q == StActive),
    .expire_o(wd_expire)
  );

  always_ff @(posedge i_arb_clk or negedge i_arb_rst_n) begin
    if (!i_arb_rst_n) begin
      state_q    <= StIdle;
      sel_q      <= SDR_SEL;
      gnt_q      <= '0;
      age_q      <= '0;
      sdr_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.i_arb_en && (bus.i_arb_req != '0)) begin
            sel_q      <= winner;
            sdr_pend_q <= bus.i_arb_req[SDR_IDX];
            state_q    <= StSetup;
          end
        end
        StSetup: begin
          // Age only moves when the arbitration turns into a real grant.
          if (req_sel) begin
            gnt_q   <= sel_to_onehot(sel_q);
            state_q <= StActive;
            if (sel_q == SDR_SEL || !sdr_pend_q) begin
              age_q <= '0;
            end else if (age_q != AgeSat) begin
              age_q <= age_q + 1'b1;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StActive: begin
          if (done_sel || wd_expire) begin
            gnt_q   <= '0;
            state_q <= StRelease;
          end
        end
        StRelease: begin
          state_q <= StIdle;
        end
        default: begin
          gnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.o_arb_gnt     = gnt_q;
  assign bus.o_arb_mux_sel = sel_q;
  assign bus.o_arb_busy    = (state_q != StIdle);
  assign bus.o_arb_abort   = abort;
  assign bus.o_arb_timeout = abort;

endmodule

// File: tb/tb_i3c_engine_arbiter.sv
// Directed self-checking bench for i3c_engine_arbiter with a grant scoreboard.
module tb_i3c_engine_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  typedef struct packed {
    logic [4:0] gnt;
    logic [2:0] sel;
  } exp_t;

  exp_t exp_q[$];

  i3c_engine_arbiter_if bus ();

  i3c_engine_arbiter #(
    .TO_CYCLES(8),
    .AGE_MAX  (4)
  ) dut (
    .i_arb_clk  (clk),
    .i_arb_rst_n(rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] g, input logic [2:0] s);
    exp_t e;
    e.gnt = g;
    e.sel = s;
    exp_q.push_back(e);
  endtask

  // Steps until a grant appears; zeros counts the gnt==0 samples seen on the way.
  task automatic wait_gnt(output int zeros);
    int   n;
    logic got;
    exp_t e;
    n = 0;
    got = 1'b0;
    zeros = 0;
    while (!got && n < 20) begin
      step();
      n++;
      if (bus.o_arb_gnt != 5'b0) got = 1'b1;
      else zeros++;
    end
    check("grant_seen", 32'(got), 32'd1);
    if (got) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_gnt", 32'(bus.o_arb_gnt), 32'(e.gnt));
        check("sb_mux_sel", 32'(bus.o_arb_mux_sel), 32'(e.sel));
      end
    end
  endtask

  task automatic finish(input int idx, input logic keep);
    bus.i_arb_done[idx] = 1'b1;
    if (!keep) bus.i_arb_req[idx] = 1'b0;
    step();
    bus.i_arb_done = 5'b0;
    check("release_gnt", 32'(bus.o_arb_gnt), 32'd0);
  endtask

  initial begin
    int z;
    bus.i_arb_en   = 1'b1;
    bus.i_arb_req  = 5'b11111;
    bus.i_arb_done = 5'b0;

    // Reset with everything requesting.
    step();
    step();
    check("rst_gnt", 32'(bus.o_arb_gnt), 32'd0);
    check("rst_mux_sel", 32'(bus.o_arb_mux_sel), 32'd0);
    check("rst_busy", 32'(bus.o_arb_busy), 32'd0);
    check("rst_abort", 32'(bus.o_arb_abort), 32'd0);
    rst_n = 1'b1;
    push(5'b00010, 3'd1);
    step();
    check("setup_mux_sel", 32'(bus.o_arb_mux_sel), 32'd1);
    check("setup_gnt", 32'(bus.o_arb_gnt), 32'd0);
    check("setup_busy", 32'(bus.o_arb_busy), 32'd1);
    wait_gnt(z);
    check("first_gnt_latency", 32'(z), 32'd0);
    bus.i_arb_req = 5'b0;
    finish(1, 1'b0);
    step();
    check("idle_busy", 32'(bus.o_arb_busy), 32'd0);
    check("idle_mux_hold", 32'(bus.o_arb_mux_sel), 32'd1);

    // Three simultaneous requests served in priority order.
    bus.i_arb_req = 5'b11100;
    push(5'b00100, 3'd2);
    push(5'b01000, 3'd3);
    push(5'b10000, 3'd4);
    wait_gnt(z);
    finish(2, 1'b0);
    wait_gnt(z);
    check("handover_gap_daa", 32'(z), 32'd2);
    finish(3, 1'b0);
    wait_gnt(z);
    check("handover_gap_sc", 32'(z), 32'd2);
    finish(4, 1'b0);
    step();
    step();
    check("prio_idle", 32'(bus.o_arb_busy), 32'd0);

    // SDR starvation guard: IBI wins four times, SDR forced on the fifth.
    bus.i_arb_req = 5'b00011;
    for (int k = 0; k < 4; k++) begin
      push(5'b00010, 3'd1);
      wait_gnt(z);
      finish(1, 1'b1);
    end
    push(5'b00001, 3'd0);
    wait_gnt(z);
    bus.i_arb_done = 5'b01000;
    step();
    bus.i_arb_done = 5'b0;
    check("foreign_done_gnt", 32'(bus.o_arb_gnt), 32'h01);
    check("foreign_done_busy", 32'(bus.o_arb_busy), 32'd1);
    finish(0, 1'b0);
    push(5'b00010, 3'd1);
    wait_gnt(z);
    finish(1, 1'b0);
    step();
    step();

    // Watchdog expiry on the eighth ACTIVE cycle.
    bus.i_arb_req = 5'b01000;
    push(5'b01000, 3'd3);
    wait_gnt(z);
    check("wd_abort_c1", 32'(bus.o_arb_abort), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("wd_abort_early", 32'({bus.o_arb_abort, bus.o_arb_timeout}), 32'd0);
    end
    step();
    check("wd_abort", 32'(bus.o_arb_abort), 32'd1);
    check("wd_timeout", 32'(bus.o_arb_timeout), 32'd1);
    check("wd_gnt_held", 32'(bus.o_arb_gnt), 32'h08);
    bus.i_arb_req = 5'b0;
    step();
    check("wd_gnt_drop", 32'(bus.o_arb_gnt), 32'd0);
    check("wd_abort_pulse", 32'(bus.o_arb_abort), 32'd0);
    check("wd_release_busy", 32'(bus.o_arb_busy), 32'd1);
    step();
    check("wd_idle", 32'(bus.o_arb_busy), 32'd0);

    // done on the expiry cycle beats the watchdog.
    bus.i_arb_req = 5'b01000;
    push(5'b01000, 3'd3);
    wait_gnt(z);
    repeat (7) step();
    bus.i_arb_done = 5'b01000;
    #1;
    check("tie_abort", 32'(bus.o_arb_abort), 32'd0);
    check("tie_timeout", 32'(bus.o_arb_timeout), 32'd0);
    bus.i_arb_req = 5'b0;
    step();
    bus.i_arb_done = 5'b0;
    check("tie_gnt_drop", 32'(bus.o_arb_gnt), 32'd0);
    step();

    // SDR drops its request during SETUP.
    bus.i_arb_req = 5'b00001;
    step();
    check("drop_setup_mux", 32'(bus.o_arb_mux_sel), 32'd0);
    check("drop_setup_busy", 32'(bus.o_arb_busy), 32'd1);
    bus.i_arb_req = 5'b0;
    step();
    check("drop_gnt", 32'(bus.o_arb_gnt), 32'd0);
    check("drop_idle", 32'(bus.o_arb_busy), 32'd0);
    step();
    check("drop_gnt_late", 32'(bus.o_arb_gnt), 32'd0);

    // Enable removed mid-transfer; new requests wait for enable.
    bus.i_arb_req = 5'b00100;
    push(5'b00100, 3'd2);
    wait_gnt(z);
    bus.i_arb_en = 1'b0;
    step();
    step();
    check("en_off_gnt_kept", 32'(bus.o_arb_gnt), 32'h04);
    finish(2, 1'b0);
    step();
    bus.i_arb_req = 5'b00010;
    for (int k = 0; k < 4; k++) begin
      step();
      check("en_off_no_gnt", 32'({bus.o_arb_busy, bus.o_arb_gnt}), 32'd0);
    end
    bus.i_arb_en = 1'b1;
    push(5'b00010, 3'd1);
    wait_gnt(z);
    check("en_on_latency", 32'(z), 32'd1);
    finish(1, 1'b0);
    step();
    step();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
